id_ex_pipe_reg: RTL and testbench

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

---
 rtl/id_ex_pipe_reg.sv | 120 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register built as a two-entry skid buffer (main + skid) with valid/ready
// handshakes, flush squash, bubble-safe control output and saturating perf counters.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 14,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [XLEN-1:0]   npc_in,
  input  logic [XLEN-1:0]   rd1_in,
  input  logic [XLEN-1:0]   rd2_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [RA_W-1:0]   rs_in,
  input  logic [RA_W-1:0]   rt_in,
  input  logic [RA_W-1:0]   rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [XLEN-1:0]   npc_out,
  output logic [XLEN-1:0]   rd1_out,
  output logic [XLEN-1:0]   rd2_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [RA_W-1:0]   rs_out,
  output logic [RA_W-1:0]   rt_out,
  output logic [RA_W-1:0]   rd_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   npc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
  } entry_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, in_e;
  logic   accept, pop, ld_main_in, ld_main_skid, ld_skid;

  assign in_e = '{ctrl: ctrl_in, npc: npc_in, rd1: rd1_in, rd2: rd2_in,
                  imm: imm_in, rs: rs_in, rt: rt_in, rd: rd_in};

  // Handshake flags come from registered state only, so no input-to-ready path exists.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt  = ONE;
        ld_main_in = 1'b1;
      end
      ONE: begin
        if (accept && pop) ld_main_in = 1'b1;
        else if (accept) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (pop) state_nxt = EMPTY;
      end
      TWO: if (pop) begin
        state_nxt    = ONE;
        ld_main_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
      // Flush squashes control only; stale data is harmless behind a zero control bundle.
      if (flush) begin
        state       <= EMPTY;
        main_q.ctrl <= '0;
        skid_q.ctrl <= '0;
      end else begin
        state <= state_nxt;
        if (ld_main_in) main_q <= in_e;
        else if (ld_main_skid) main_q <= skid_q;
        if (ld_skid) skid_q <= in_e;
      end
    end
  end

  assign ctrl_out = out_valid ? main_q.ctrl : '0;
  assign npc_out  = main_q.npc;
  assign rd1_out  = main_q.rd1;
  assign rd2_out  = main_q.rd2;
  assign imm_out  = main_q.imm;
  assign rs_out   = main_q.rs;
  assign rt_out   = main_q.rt;
  assign rd_out   = main_q.rd;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg (XLEN=64, RA_W=6, CNT_W=4): directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_id_ex_pipe_reg;
  localparam int XW = 64, CW = 14, RW = 6, NW = 4;
  localparam int CMAX = (1 << NW) - 1;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [XW-1:0] npc, rd1, rd2, imm;
    logic [RW-1:0] rs, rt, rd;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] ctrl_in, ctrl_out;
  logic [XW-1:0] npc_in, rd1_in, rd2_in, imm_in, npc_out, rd1_out, rd2_out, imm_out;
  logic [RW-1:0] rs_in, rt_in, rd_in, rs_out, rt_out, rd_out;
  logic [NW-1:0] stall_cnt, bubble_cnt;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XW), .CTRL_W(CW), .RA_W(RW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .npc_in(npc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .npc_out(npc_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
    .imm_out(imm_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

  int   checks = 0, errors = 0;
  bit   armed = 0;
  ent_t q[$];
  ent_t last = '0;
  int   m_stall = 0, m_bubble = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.ctrl = CW'($urandom);
    e.npc  = {$urandom, $urandom};
    e.rd1  = {$urandom, $urandom};
    e.rd2  = {$urandom, $urandom};
    e.imm  = {$urandom, $urandom};
    e.rs   = RW'($urandom);
    e.rt   = RW'($urandom);
    e.rd   = RW'($urandom);
    return e;
  endfunction

  function automatic ent_t dir_ent(input logic [XW-1:0] npc);
    ent_t e = rnd_ent();
    e.ctrl = 14'h3FFF;
    e.npc  = npc;
    e.rs   = 6'd63;
    return e;
  endfunction

  task automatic check_model();
    bit ov = (q.size() > 0);
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("ctrl_out", 64'(ctrl_out), ov ? 64'(last.ctrl) : 64'd0);
    chk("npc_out", npc_out, last.npc);
    chk("rd1_out", rd1_out, last.rd1);
    chk("rd2_out", rd2_out, last.rd2);
    chk("imm_out", imm_out, last.imm);
    chk("rs_out", 64'(rs_out), 64'(last.rs));
    chk("rt_out", 64'(rt_out), 64'(last.rt));
    chk("rd_out", 64'(rd_out), 64'(last.rd));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
  endtask

  // One clock: drive, compare pre-edge outputs, then advance the model at the edge.
  task automatic step(input logic r, input logic f, input logic iv, input logic ordy, input ent_t e);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    ctrl_in = e.ctrl; npc_in = e.npc; rd1_in = e.rd1; rd2_in = e.rd2; imm_in = e.imm;
    rs_in = e.rs; rt_in = e.rt; rd_in = e.rd;
    #1;
    if (armed) check_model();
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_stall = 0; m_bubble = 0; last = '0;
      armed = 1;
    end else begin
      if (q.size() > 0 && !ordy && m_stall < CMAX) m_stall++;
      if (q.size() == 0 && m_bubble < CMAX) m_bubble++;
      if (f) q.delete();
      else begin
        bit pop = (q.size() > 0) && ordy;
        bit acc = iv && (q.size() < 2);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      if (q.size() > 0) last = q[0];
    end
    #1;
  endtask

  initial begin
    ent_t z = '0;
    step(0, 0, 0, 0, z);
    step(0, 1, 1, 1, rnd_ent());
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_npc", npc_out, 64'd0);

    // streaming
    step(1, 0, 1, 1, dir_ent(64'd4));
    chk("strm_npc4", npc_out, 64'd4);
    step(1, 0, 1, 1, dir_ent(64'd8));
    chk("strm_npc8", npc_out, 64'd8);
    step(1, 0, 1, 1, dir_ent(64'd12));
    chk("strm_npc12", npc_out, 64'd12);
    chk("strm_ctrl", 64'(ctrl_out), 64'h3FFF);
    chk("strm_stall", 64'(stall_cnt), 64'd0);
    step(1, 0, 0, 1, z);
    chk("strm_drain", 64'(out_valid), 64'd0);

    // backpressure with full-width npc
    step(1, 0, 1, 0, dir_ent(64'h10));
    step(1, 0, 1, 0, dir_ent(64'hFFFF_FFFF_FFFF_FFFC));
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_npc_head", npc_out, 64'h10);
    chk("bp_rs", 64'(rs_out), 64'd63);
    step(1, 0, 0, 1, z);
    chk("bp_npc_2nd", npc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 0, 1, z);
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_ctrl_bubble", 64'(ctrl_out), 64'd0);

    // flush in TWO, offered entry discarded
    step(1, 0, 1, 0, dir_ent(64'h30));
    step(1, 0, 1, 0, dir_ent(64'h40));
    step(1, 1, 1, 0, dir_ent(64'hDEAD));
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl", 64'(ctrl_out), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    step(1, 0, 0, 1, z);
    chk("fl_no_ghost", 64'(out_valid), 64'd0);

    // stall counter saturation
    step(1, 0, 1, 0, dir_ent(64'h50));
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, z);
    chk("sat_stall", 64'(stall_cnt), 64'd15);
    step(1, 0, 0, 0, z);
    chk("sat_hold", 64'(stall_cnt), 64'd15);

    // reset in TWO
    step(1, 0, 1, 0, dir_ent(64'h60));
    step(0, 1, 1, 1, dir_ent(64'h70));
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd1);
    chk("mrst_npc", npc_out, 64'd0);
    chk("mrst_stall", 64'(stall_cnt), 64'd0);
    chk("mrst_bubble", 64'(bubble_cnt), 64'd0);
    step(1, 0, 0, 0, z);
    chk("mrst_after", 64'(out_valid), 64'd0);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
           1'($urandom), 1'($urandom), rnd_ent());
    step(1, 0, 0, 1, z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
